// File: rtl/i2c_target_regs.sv
// I2C target with a small register file, host read port and write-notify strobe.
// Optional SCL-stuck-low abort is compiled in with `define I2C_TARGET_TIMEOUT_EN.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         FILTER_LEN  = 3,
  parameter int         TIMEOUT_CYC = 65535,
  localparam int        AW          = $clog2(NUM_REGS)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          SCL_IN,
  input  logic          SDA_IN,
  output logic          SDA_OUT,
  input  logic [AW-1:0] HOST_ADR,
  output logic [7:0]    HOST_DAT,
  output logic          WR_STB,
  output logic [AW-1:0] WR_ADR,
  output logic [7:0]    WR_DAT,
  output logic          BUSY,
  output logic [3:0]    DBG_STATE
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_PTR       = 4'd3,
    S_PTR_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RACK      = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Index 0 carries SCL, index 1 carries SDA through the same synchronizer/filter.
  logic [1:0]    r_sync1;
  logic [1:0]    r_sync2;
  logic [1:0]    r_flt;
  logic [1:0]    r_flt_d;
  logic [FW-1:0] r_fcnt [2];

  logic          r_sda_out;
  logic          r_busy;
  logic          r_wr_stb;
  logic [AW-1:0] r_wr_adr;
  logic [7:0]    r_wr_dat;
  logic [AW-1:0] r_ptr;
  logic [6:0]    r_shift;
  logic [2:0]    r_bcnt;
  logic          r_phase;
  logic          r_rw;
  logic [7:0]    r_regs [NUM_REGS];

  logic          w_scl;
  logic          w_sda;
  logic          w_scl_rise;
  logic          w_scl_fall;
  logic          w_start;
  logic          w_stop;
  logic          w_last;
  logic          w_timeout;
  logic [7:0]    w_byte;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
      r_flt   <= 2'b11;
      r_flt_d <= 2'b11;
      for (int i = 0; i < 2; i++) r_fcnt[i] <= '0;
    end else begin
      r_sync1 <= {SDA_IN, SCL_IN};
      r_sync2 <= r_sync1;
      r_flt_d <= r_flt;
      // A level is accepted on its FILTER_LEN-th consecutive differing sample.
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_flt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
          r_flt[i]  <= r_sync2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_scl      = r_flt[0];
  assign w_sda      = r_flt[1];
  assign w_scl_rise = r_flt[0] & ~r_flt_d[0];
  assign w_scl_fall = ~r_flt[0] & r_flt_d[0];
  assign w_start    = ~r_flt[1] & r_flt_d[1] & r_flt[0] & r_flt_d[0];
  assign w_stop     = r_flt[1] & ~r_flt_d[1] & r_flt[0] & r_flt_d[0];
  assign w_last     = w_scl_rise && (r_bcnt == 3'd7);
  assign w_byte     = {r_shift, w_sda};

`ifdef I2C_TARGET_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_to_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_to_cnt <= '0;
    end else if (r_busy && !w_scl) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end else begin
      r_to_cnt <= '0;
    end
  end

  assign w_timeout = r_busy & ~w_scl & (r_to_cnt == TW'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop || w_timeout) begin
      w_state_nxt = S_IDLE;
    end else if (w_start) begin
      w_state_nxt = S_ADDR;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_last) w_state_nxt = (w_byte[7:1] == DEV_ADDR) ? S_ADDR_ACK : S_IGNORE;
        end
        S_ADDR_ACK: begin
          if (w_scl_fall && r_phase) w_state_nxt = r_rw ? S_RDATA : S_PTR;
        end
        S_PTR: begin
          if (w_last) w_state_nxt = S_PTR_ACK;
        end
        S_PTR_ACK: begin
          if (w_scl_fall && r_phase) w_state_nxt = S_WDATA;
        end
        S_WDATA: begin
          if (w_last) w_state_nxt = S_WDATA_ACK;
        end
        S_WDATA_ACK: begin
          if (w_scl_fall && r_phase) w_state_nxt = S_WDATA;
        end
        S_RDATA: begin
          if (w_last) w_state_nxt = S_RACK;
        end
        S_RACK: begin
          if (w_scl_rise && w_sda)        w_state_nxt = S_IGNORE;
          else if (w_scl_fall && r_phase) w_state_nxt = S_RDATA;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // r_phase marks that the 9th SCL rise of an ACK slot has been seen.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sda_out <= 1'b1;
      r_busy    <= 1'b0;
      r_wr_stb  <= 1'b0;
      r_wr_adr  <= '0;
      r_wr_dat  <= '0;
      r_ptr     <= '0;
      r_shift   <= '0;
      r_bcnt    <= '0;
      r_phase   <= 1'b0;
      r_rw      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_stb <= 1'b0;
      if (w_stop || w_timeout) begin
        r_sda_out <= 1'b1;
        r_busy    <= 1'b0;
        r_bcnt    <= '0;
        r_phase   <= 1'b0;
      end else if (w_start) begin
        r_sda_out <= 1'b1;
        r_bcnt    <= '0;
        r_phase   <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift <= w_byte[6:0];
              r_bcnt  <= r_bcnt + 1'b1;
              if (w_last && (w_byte[7:1] == DEV_ADDR)) begin
                r_busy <= 1'b1;
                r_rw   <= w_byte[0];
              end
            end
          end
          S_PTR: begin
            if (w_scl_rise) begin
              r_shift <= w_byte[6:0];
              r_bcnt  <= r_bcnt + 1'b1;
              if (w_last) r_ptr <= w_byte[AW-1:0];
            end
          end
          S_WDATA: begin
            if (w_scl_rise) begin
              r_shift <= w_byte[6:0];
              r_bcnt  <= r_bcnt + 1'b1;
              if (w_last) begin
                r_regs[r_ptr] <= w_byte;
                r_wr_stb      <= 1'b1;
                r_wr_adr      <= r_ptr;
                r_wr_dat      <= w_byte;
                r_ptr         <= r_ptr + 1'b1;
              end
            end
          end
          S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
            if (w_scl_rise) r_phase <= 1'b1;
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_sda_out <= 1'b0;
              end else begin
                r_phase <= 1'b0;
                r_bcnt  <= '0;
                if (r_state == S_ADDR_ACK && r_rw) begin
                  r_shift   <= r_regs[r_ptr][6:0];
                  r_sda_out <= r_regs[r_ptr][7];
                end else begin
                  r_sda_out <= 1'b1;
                end
              end
            end
          end
          S_RDATA: begin
            if (w_scl_rise) r_bcnt <= r_bcnt + 1'b1;
            if (w_scl_fall) begin
              r_sda_out <= r_shift[6];
              r_shift   <= {r_shift[5:0], 1'b0};
            end
          end
          S_RACK: begin
            if (w_scl_rise) begin
              r_phase <= 1'b1;
              if (!w_sda) r_ptr <= r_ptr + 1'b1;
            end
            if (w_scl_fall) begin
              if (!r_phase) begin
                r_sda_out <= 1'b1;
              end else begin
                r_phase   <= 1'b0;
                r_bcnt    <= '0;
                r_shift   <= r_regs[r_ptr][6:0];
                r_sda_out <= r_regs[r_ptr][7];
              end
            end
          end
          default: r_sda_out <= 1'b1;
        endcase
      end
    end
  end

  assign SDA_OUT   = r_sda_out;
  assign BUSY      = r_busy;
  assign WR_STB    = r_wr_stb;
  assign WR_ADR    = r_wr_adr;
  assign WR_DAT    = r_wr_dat;
  assign HOST_DAT  = r_regs[HOST_ADR];
  assign DBG_STATE = r_state;

endmodule

// File: doc/i2c_target_regs.md
Name: i2c_target_regs

Overview:
- I2C target (slave): the far end of the bus that the Picoblaze bit-bang master drives.
- Contains a small register file that is written and read over I2C, plus a host-side read port and a write-notify strobe for fabric logic.
- Used as an on-board loopback target for the config firmware, and as a control port for an external I2C master.
- Fully synchronous to CLK; SCL/SDA are oversampled; no clock stretching.

Parameters:
- DEV_ADDR, 7'h50, 7-bit target address matched after START.
- NUM_REGS, 16, register count; power of two, 2..256.
- FILTER_LEN, 3, consecutive equal samples required before a synchronized SCL/SDA level is accepted.
- TIMEOUT_CYC, 65535, CLK cycles of SCL stuck low before abort (optional feature only).

Ports:
- CLK  in  1  master clock
- RST_N  in  1  asynchronous active-low reset
- SCL_IN  in  1  bus SCL (from pad)
- SDA_IN  in  1  bus SDA (from pad)
- SDA_OUT  out  1  open-drain control: 0 = pull SDA low, 1 = release
- HOST_ADR  in  log2(NUM_REGS)  host read address
- HOST_DAT  out  8  register[HOST_ADR], combinational read
- WR_STB  out  1  one-cycle pulse per I2C data byte written
- WR_ADR  out  log2(NUM_REGS)  register index of that write
- WR_DAT  out  8  data byte of that write
- BUSY  out  1  high from an address-matched START until STOP/abort

Behaviour:
- Reset: SDA_OUT=1, WR_STB=0, WR_ADR=0, WR_DAT=0, BUSY=0, all registers 8'h00, pointer=0, state IDLE; filters preset to 1.
- Input path: 2-flop synchronizer, then filter. A new level is accepted only after FILTER_LEN equal samples. Edge detect runs on filtered values. Input-to-action latency is 2+FILTER_LEN cycles.
- START: filtered SDA 1->0 while SCL=1. Accepted in any state, including a repeated START; goes to ADDR with bit counter 0.
- STOP: filtered SDA 0->1 while SCL=1. Goes to IDLE, BUSY=0, SDA_OUT=1.
- Bit sampling: on filtered SCL rising edge, MSB first.
- SDA_OUT changes only on the cycle after a filtered SCL falling edge.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits. If addr==DEV_ADDR, go to ADDR_ACK and set BUSY=1; otherwise go to IGNORE.
  - ADDR_ACK: drive 0 for the 9th clock. Then RW=0 -> PTR; RW=1 -> load shift register from reg[pointer], then RDATA.
  - PTR: 8 bits -> pointer = byte mod NUM_REGS -> PTR_ACK (ACK) -> WDATA.
  - WDATA: 8 bits -> WDATA_ACK (ACK). WR_STB pulses one cycle on the SCL rising edge of the 8th bit, with WR_ADR=pointer and WR_DAT=byte. reg[pointer] updates on the same edge. Pointer increments and wraps NUM_REGS-1 -> 0.
  - RDATA: drive shift-register MSB after each SCL fall for 8 bits -> RACK. SDA is released during the 9th bit.
  - RACK: sample master ACK on SCL rise. ACK(0) -> pointer++, reload, RDATA. NACK(1) -> IGNORE.
  - IGNORE: SDA_OUT=1; wait for START or STOP.
- Pointer persists across transactions; a read with no preceding pointer byte starts at the last pointer.
- ACK is held from the SCL fall after bit 8 to the SCL fall after bit 9.
- Host read of a register written by I2C in the same cycle returns the old value; the new value appears next cycle.
- Reset mid-transfer: immediate return to reset values and SDA released; the bus recovers on the next START.

Optional Feature:
- Macro I2C_TARGET_TIMEOUT_EN.
- Defined: a counter runs while BUSY=1 and filtered SCL=0, and clears on SCL high. At TIMEOUT_CYC it forces IDLE, SDA_OUT=1, BUSY=0. Register contents and the pointer are unaffected.
- Undefined: no counter and no timeout; the block stays in its current state indefinitely; TIMEOUT_CYC is unused.

Test Plan:
- Write 0xA0, ptr 0x03, data 0x5A, 0xC3, STOP -> ACK on all 4 bytes; WR_STB twice (adr 3 dat 5A, adr 4 dat C3); HOST_ADR=4 gives HOST_DAT=C3.
- Write 0xA0 ptr 0x02, repeated START, 0xA1, read 3 bytes, ACK, ACK, NACK -> returns reg2, reg3, reg4; SDA released after NACK; BUSY=0 after STOP.
- Write ptr 0x0F with data 11, 22 (NUM_REGS=16) -> reg15=11, reg0=22 (wrap).
- Address 0xA2 -> no ACK (SDA_OUT stays 1); IGNORE until STOP; BUSY stays 0; no WR_STB.
- 1-cycle glitch on SDA while SCL high (FILTER_LEN=3) -> no START/STOP detected; transfer continues intact.
- With I2C_TARGET_TIMEOUT_EN and TIMEOUT_CYC=100: hold SCL low 100 cycles mid-byte -> BUSY=0 and SDA_OUT=1; a following valid transaction succeeds.
